// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg -- shared CPU definitions.
//   md_op_e    : multiply/divide unit operation codes (MULT, MULTU, DIV, DIVU)
//   md_state_e : multiply/divide sequencer states
//   alu_op_e   : integer ALU operation codes
//   MD_ITERS   : iterations of the multiply/divide step loop (one per operand bit)
package mips_cpu_pkg;

   localparam int MD_ITERS = 32;
   localparam int MD_CNT_W = $clog2(MD_ITERS);

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2
   } md_state_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } alu_op_e;

endpackage

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv -- iterative 32-bit multiply/divide unit with HI/LO registers.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   start, op, a, b  : launch MULT/MULTU/DIV/DIVU on rs (a) and rt (b), IDLE only
//   hi_we, lo_we,
//   wdata            : MTHI/MTLO writes, honoured only when idle
//   busy             : operation in flight (RUN/FIX)
//   done             : one-cycle pulse when HI/LO take a new result
//   hi, lo           : HI/LO architectural registers
// Operands are converted to magnitudes at launch, 32 unsigned steps run on a
// shared 64-bit shift register and 33-bit adder, and signs are fixed up in FIX.
module mips_cpu_muldiv
   import mips_cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e             state_q, state_d;
   md_op_e                op_q, op_d;
   logic [63:0]           sr_q, sr_d;      // MUL: {acc, multiplier}  DIV: {rem, dividend/quotient}
   logic [31:0]           opnd_q, opnd_d;  // multiplicand or divisor magnitude
   logic [31:0]           a_q, a_d;        // raw dividend, returned in HI on divide by zero
   logic                  sa_q, sa_d;
   logic                  sb_q, sb_d;
   logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]           hi_q, hi_d;
   logic [31:0]           lo_q, lo_d;
   logic                  done_q, done_d;

   logic                  is_mul;
   logic [32:0]           add_x, add_y, add_sum;
   logic                  new_signed;
   logic                  new_sa, new_sb;
   logic [63:0]           prod_fix;
   logic [31:0]           quo_fix, rem_fix;

   assign is_mul = (op_q == MD_MULT) || (op_q == MD_MULTU);

   // Shared adder: MUL adds the multiplicand to the upper half; DIV subtracts
   // the divisor from the upper half shifted left by one (33-bit minuend).
   // Because the partial remainder is always below the divisor, bit 32 of the
   // difference is exactly the borrow.
   assign add_x   = is_mul ? {1'b0, sr_q[63:32]} : sr_q[63:31];
   assign add_y   = is_mul ? {1'b0, opnd_q} : ~{1'b0, opnd_q};
   assign add_sum = add_x + add_y + {32'd0, ~is_mul};

   assign new_signed = (md_op_e'(op) == MD_MULT) || (md_op_e'(op) == MD_DIV);
   assign new_sa     = new_signed & a[31];
   assign new_sb     = new_signed & b[31];

   // Sign flags are zero for unsigned ops, so no op qualification is needed.
   assign prod_fix = (sa_q ^ sb_q) ? -sr_q : sr_q;
   assign quo_fix  = (sa_q ^ sb_q) ? -sr_q[31:0] : sr_q[31:0];
   assign rem_fix  = sa_q ? -sr_q[63:32] : sr_q[63:32];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      sr_d    = sr_q;
      opnd_d  = opnd_q;
      a_d     = a_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         MD_IDLE: begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start) begin
               state_d = MD_RUN;
               op_d    = md_op_e'(op);
               sa_d    = new_sa;
               sb_d    = new_sb;
               a_d     = a;
               sr_d    = {32'd0, new_sa ? -a : a};
               opnd_d  = new_sb ? -b : b;
               cnt_d   = MD_CNT_W'(MD_ITERS - 1);
            end
         end
         MD_RUN: begin
            if (is_mul)
               sr_d = sr_q[0] ? {add_sum, sr_q[31:1]} : {1'b0, sr_q[63:1]};
            else
               sr_d = add_sum[32] ? {sr_q[62:0], 1'b0} : {add_sum[31:0], sr_q[30:0], 1'b1};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = MD_FIX;
         end
         MD_FIX: begin
            if (is_mul) begin
               {hi_d, lo_d} = prod_fix;
            end else if (opnd_q == 32'd0) begin
               lo_d = 32'hFFFF_FFFF;
               hi_d = a_q;
            end else begin
               lo_d = quo_fix;
               hi_d = rem_fix;
            end
            done_d  = 1'b1;
            state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= MD_IDLE;
         op_q    <= MD_MULT;
         sr_q    <= '0;
         opnd_q  <= '0;
         a_q     <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sr_q    <= sr_d;
         opnd_q  <= opnd_d;
         a_q     <= a_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != MD_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv -- randomized and directed checks of mips_cpu_muldiv
// against a plain-arithmetic HI/LO reference model.
module tb_mips_cpu_muldiv;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        hi_we, lo_we;
   logic [31:0] wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   // Reference architectural state
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   mips_cpu_muldiv dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Returns {hi, lo} straight from the arithmetic definition of each op.
   function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = $signed(av);
      sb = $signed(bv);
      ua = {32'd0, av};
      ub = {32'd0, bv};
      case (o)
         2'd0: ref_md = sa * sb;
         2'd1: ref_md = ua * ub;
         2'd2: begin
            if (bv == 32'd0) ref_md = {av, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               ref_md = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (bv == 32'd0) ref_md = {av, 32'hFFFF_FFFF};
            else ref_md = {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
         end
      endcase
   endfunction

   // Launch one op in cycle 0, observe cycles 1..36. Optionally pulse
   // start+MTHI(32'h1234) in cycle inj (1..33), or MTHI/MTLO together with start.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input int inj, input bit we_with_start);
      logic [63:0] r;
      logic [31:0] rhi, rlo;
      int bad_busy, first_done, done_n;
      @(negedge clk);
      start = 1'b1; op = o; a = av; b = bv;
      if (we_with_start) begin
         wdata = $urandom;
         hi_we = 1'b1; lo_we = 1'b1;
         m_hi = wdata; m_lo = wdata;
      end
      r = ref_md(o, av, bv);
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      bad_busy = 0; first_done = -1; done_n = 0; rhi = 32'd0; rlo = 32'd0;
      for (int n = 1; n <= 36; n++) begin
         if (busy !== (n <= 33)) bad_busy++;
         if (done === 1'b1) begin
            done_n++;
            if (first_done < 0) first_done = n;
         end
         if (n == 20) chk({tag, " hold"}, {hi, lo}, {m_hi, m_lo});
         if (n == 34) begin rhi = hi; rlo = lo; end
         if (n == inj) begin
            start = 1'b1; hi_we = 1'b1; wdata = 32'h1234;
            op = 2'($urandom); a = $urandom; b = $urandom;
         end
         @(negedge clk);
         start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      m_hi = r[63:32];
      m_lo = r[31:0];
      chk({tag, " busy_window_errs"}, 64'(bad_busy), 64'd0);
      chk({tag, " done_cycle"}, 64'(first_done), 64'd34);
      chk({tag, " done_pulses"}, 64'(done_n), 64'd1);
      chk({tag, " hi"}, {32'd0, rhi}, {32'd0, m_hi});
      chk({tag, " lo"}, {32'd0, rlo}, {32'd0, m_lo});
   endtask

   task automatic mt_write(input bit wh, input bit wl, input logic [31:0] d);
      @(negedge clk);
      hi_we = wh; lo_we = wl; wdata = d;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      if (wh) m_hi = d;
      if (wl) m_lo = d;
      chk("mt hi", {32'd0, hi}, {32'd0, m_hi});
      chk("mt lo", {32'd0, lo}, {32'd0, m_lo});
      chk("mt done", {63'd0, done}, 64'd0);
   endtask

   initial begin
      int dn;
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      reset = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst busy", {63'd0, busy}, 64'd0);
      chk("rst done", {63'd0, done}, 64'd0);
      chk("rst hilo", {hi, lo}, 64'd0);
      reset = 1'b0;

      mt_write(1'b0, 1'b1, 32'h0000_CAFE);
      mt_write(1'b1, 1'b0, 32'h5555_AAAA);
      mt_write(1'b1, 1'b1, 32'h0BAD_F00D);

      run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
      chk("multu_max exact", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);
      run_op("mult_neg",  2'd0, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
      chk("mult_neg exact", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op("div_neg",   2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      chk("div_neg exact", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("divu_zero", 2'd3, 32'd100, 32'd0, 0, 1'b0);
      chk("divu_zero exact", {m_hi, m_lo}, {32'd100, 32'hFFFF_FFFF});
      run_op("div_zero",  2'd2, 32'h8765_4321, 32'd0, 0, 1'b0);
      run_op("div_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      chk("div_ovf exact", {m_hi, m_lo}, {32'd0, 32'h8000_0000});
      run_op("protect",   2'd2, 32'd1000, 32'd7, 10, 1'b0);
      run_op("protect_fix", 2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 33, 1'b0);
      run_op("we_start",  2'd1, 32'hDEAD_BEEF, 32'h0000_1003, 0, 1'b1);

      // Reset during cycle 10 of a DIV aborts without a result.
      @(negedge clk);
      start = 1'b1; op = 2'd2; a = 32'd12345; b = 32'd17;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort busy", {63'd0, busy}, 64'd0);
      chk("abort hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;
      dn = 0;
      for (int n = 0; n < 40; n++) begin
         if (done === 1'b1 || busy === 1'b1) dn++;
         @(negedge clk);
      end
      chk("abort quiet", 64'(dn), 64'd0);
      run_op("post_rst", 2'd3, 32'hFFFF_0000, 32'd3, 0, 1'b0);

      // Random ops with occasional corner operands and MT writes.
      for (int i = 0; i < 30; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = $urandom_range(1, 15);
            3: rb = -($urandom_range(1, 15));
            default: ;
         endcase
         if ($urandom_range(0, 3) == 0) mt_write(1'($urandom), 1'($urandom), $urandom);
         run_op("rand", ro, ra, rb, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 33) : 0,
                1'($urandom_range(0, 4) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_cpu_muldiv.md
MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

Interface
REQ-001 Parameters SHALL be none; operand width is fixed at 32.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request a new operation; sampled only in IDLE.
REQ-005 op  in  2  operation code: MULT=0, MULTU=1, DIV=2, DIVU=3.
REQ-006 a  in  32  rs operand, multiplicand or dividend.
REQ-007 b  in  32  rt operand, multiplier or divisor.
REQ-008 hi_we  in  1  MTHI write strobe.
REQ-009 lo_we  in  1  MTLO write strobe.
REQ-010 wdata  in  32  MTHI/MTLO data.
REQ-011 busy  out  1  high while an operation is in flight.
REQ-012 done  out  1  one-cycle pulse when HI/LO take a new result.
REQ-013 hi  out  32  HI register.
REQ-014 lo  out  32  LO register.

Function
REQ-015 FSM SHALL have states IDLE, RUN and FIX; busy SHALL be high in RUN and FIX only.
REQ-016 IDLE->RUN on start=1: latch op, latch |a| and |b| (raw values for U ops), record sign flags, load counter=31.
REQ-017 RUN SHALL perform one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle, for exactly 32 cycles, then go to FIX.
REQ-018 FIX SHALL apply sign correction and load hi/lo at its exit edge, then return to IDLE.
REQ-019 In the cycle after FIX, done SHALL be 1 and hi/lo SHALL show the result; start edge at cycle 0 gives done=1 in cycle 34.
REQ-020 MULT/MULTU SHALL give {hi,lo} = full 64-bit product; for MULT the product is negated when operand signs differ.
REQ-021 DIV/DIVU SHALL give lo=quotient, hi=remainder; for DIV the quotient is negated when signs differ and the remainder takes the sign of a.
REQ-022 Divide by zero (b=0, DIV or DIVU) SHALL use the same latency and give lo=32'hFFFF_FFFF, hi=a (original value).
REQ-023 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL give lo=32'h8000_0000, hi=0.
REQ-024 start while busy SHALL be ignored; no queuing.
REQ-025 hi_we/lo_we in IDLE SHALL write wdata at the next edge; both together SHALL write both.
REQ-026 hi_we/lo_we while busy SHALL be ignored.
REQ-027 start with hi_we/lo_we in the same IDLE cycle: the write SHALL take effect, then the result SHALL overwrite hi/lo at completion.
REQ-028 hi/lo SHALL hold their value during RUN/FIX and update only per REQ-018 or REQ-025.

Reset
REQ-029 reset SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
REQ-030 reset mid-operation SHALL abort with no result; the first start after reset deasserts SHALL follow REQ-019 timing.

Structure
REQ-031 The op encoding enum and the constant 32 (iteration count) SHALL live in the shared package mips_cpu_pkg, alongside the ALU op enum.
REQ-032 The block SHALL be a single module with no sub-module; one 64-bit shift register plus a 33-bit adder/subtractor is shared by MUL and DIV.

Verification
REQ-033 MULTU a=32'hFFFF_FFFF b=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001, done in cycle 34, busy cycles 1..33.
REQ-034 MULT a=-3 b=7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
REQ-035 DIV a=-7 b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; DIVU a=100 b=0 -> lo=32'hFFFF_FFFF, hi=100.
REQ-036 Protected inputs: start and hi_we with wdata=32'h1234 pulsed during RUN are ignored, and the first result is unaffected.
REQ-037 Reset in cycle 10 of a DIV -> hi=lo=0, busy=0, no done pulse.
REQ-038 lo_we wdata=32'hCAFE in IDLE -> lo=32'hCAFE next cycle, hi unchanged, done stays 0.
